// File: rtl/router_fsm_if.sv
// Signal bundle between the 1x3 router source/datapath (master) and router_fsm (slave).
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;
  logic       timeout;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, timeout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, timeout
  );
endinterface

// File: rtl/router_fsm.sv
// 1x3 router write-path sequencer: address decode, FIFO wait, load/full/parity phases.
// Define ROUTER_FSM_TIMEOUT_EN to abort WAIT_TILL_EMPTY after WAIT_TIMEOUT cycles.
module router_fsm #(
  parameter int unsigned WAIT_TIMEOUT = 30
) (
  input logic         clk,
  input logic         rst,
  router_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 255) begin : g_param_check
    $error("router_fsm: WAIT_TIMEOUT must be in 1..255");
  end

  state_t     state, state_next;
  logic [1:0] addr;
  logic       header_ok;
  logic       empty_in;
  logic       empty_addr;
  logic       soft_reset_addr;
  logic       timeout_hit;

  assign header_ok = bus.pkt_valid && (bus.data_in != 2'd3);

  // Empty flag of the FIFO named by the incoming header vs. the latched address.
  always_comb begin
    empty_in        = 1'b0;
    empty_addr      = 1'b0;
    soft_reset_addr = 1'b0;
    case (bus.data_in)
      2'd0:    empty_in = bus.fifo_empty_0;
      2'd1:    empty_in = bus.fifo_empty_1;
      2'd2:    empty_in = bus.fifo_empty_2;
      default: empty_in = 1'b0;
    endcase
    case (addr)
      2'd0: begin empty_addr = bus.fifo_empty_0; soft_reset_addr = bus.soft_reset_0; end
      2'd1: begin empty_addr = bus.fifo_empty_1; soft_reset_addr = bus.soft_reset_1; end
      2'd2: begin empty_addr = bus.fifo_empty_2; soft_reset_addr = bus.soft_reset_2; end
      default: ;
    endcase
  end

`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

  logic [7:0] wait_cnt;
  logic       timeout_q;

  // The cycle whose closing edge would bring the count to WAIT_TIMEOUT is the last one waited.
  assign timeout_hit = (state == WAIT_TILL_EMPTY) && !soft_reset_addr &&
                       !empty_addr && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state != WAIT_TILL_EMPTY) wait_cnt <= 8'd0;
      else                          wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DECODE_ADDRESS;
      addr  <= 2'd0;
    end else begin
      state <= state_next;
      if (state == DECODE_ADDRESS && header_ok) addr <= bus.data_in;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    if (soft_reset_addr && state != DECODE_ADDRESS) begin
      state_next = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS:
          if (header_ok) state_next = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:
          if (empty_addr)       state_next = LOAD_FIRST_DATA;
          else if (timeout_hit) state_next = DECODE_ADDRESS;
        LOAD_FIRST_DATA:
          state_next = LOAD_DATA;
        LOAD_DATA:
          if (bus.fifo_full)       state_next = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) state_next = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!bus.fifo_full) state_next = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (bus.parity_done)        state_next = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) state_next = LOAD_PARITY;
          else                        state_next = LOAD_DATA;
        LOAD_PARITY:
          state_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:
          state_next = DECODE_ADDRESS;
      endcase
    end
  end

  assign bus.detect_add    = (state == DECODE_ADDRESS);
  assign bus.lfd_state     = (state == LOAD_FIRST_DATA);
  assign bus.ld_state      = (state == LOAD_DATA);
  assign bus.full_state    = (state == FIFO_FULL_STATE);
  assign bus.laf_state     = (state == LOAD_AFTER_FULL);
  assign bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                             (state == LOAD_AFTER_FULL);
  assign bus.busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Directed-vector bench for router_fsm; output vector checked against hand-built state codes.
module tb_router_fsm;

  // {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy, timeout}
  localparam logic [8:0] S_DA   = 9'b1000_0000_0;
  localparam logic [8:0] S_LFD  = 9'b0100_0001_0;
  localparam logic [8:0] S_LD   = 9'b0010_0010_0;
  localparam logic [8:0] S_LAF  = 9'b0001_0011_0;
  localparam logic [8:0] S_FULL = 9'b0000_1001_0;
  localparam logic [8:0] S_LP   = 9'b0000_0011_0;
  localparam logic [8:0] S_CPE  = 9'b0000_0101_0;
  localparam logic [8:0] S_WTE  = 9'b0000_0001_0;
  localparam logic [8:0] S_TO   = 9'b1000_0000_1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  router_fsm_if bus ();

  router_fsm #(.WAIT_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
            bus.rst_int_reg, bus.write_enb_reg, bus.busy, bus.timeout};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle 1 ns past it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string tag, input logic [8:0] exp);
    step();
    check(tag, outs(), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pkt_valid     = 1'b0;
    bus.data_in       = 2'd0;
    bus.fifo_full     = 1'b0;
    bus.fifo_empty_0  = 1'b1;
    bus.fifo_empty_1  = 1'b1;
    bus.fifo_empty_2  = 1'b1;
    bus.soft_reset_0  = 1'b0;
    bus.soft_reset_1  = 1'b0;
    bus.soft_reset_2  = 1'b0;
    bus.parity_done   = 1'b0;
    bus.low_pkt_valid = 1'b0;

    #1 check("reset_state", outs(), S_DA);
    step();
    step();
    rst = 1'b1;
    step_check("idle_after_reset", S_DA);

    // Packet to empty FIFO 1: header, 3 payload cycles, parity
    bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
    step_check("p1_lfd", S_LFD);
    bus.data_in = 2'd0;
    step_check("p1_ld1", S_LD);
    step_check("p1_ld2", S_LD);
    step_check("p1_ld3", S_LD);
    bus.pkt_valid = 1'b0;
    step_check("p1_lp", S_LP);
    step_check("p1_cpe", S_CPE);
    step_check("p1_da", S_DA);

    // FIFO 2 non-empty: wait, then proceed when it drains
    bus.fifo_empty_2 = 1'b0;
    bus.pkt_valid = 1'b1; bus.data_in = 2'd2;
    step_check("p2_wte", S_WTE);
    step_check("p2_wte_hold", S_WTE);
    bus.fifo_empty_2 = 1'b1;
    step_check("p2_lfd", S_LFD);
    step_check("p2_ld", S_LD);
    // full and end-of-packet together: full wins
    bus.fifo_full = 1'b1; bus.pkt_valid = 1'b0;
    step_check("p2_full", S_FULL);
    step_check("p2_full_hold", S_FULL);
    bus.fifo_full = 1'b0;
    step_check("p2_laf", S_LAF);
    bus.low_pkt_valid = 1'b1;
    step_check("p2_laf_to_lp", S_LP);
    bus.low_pkt_valid = 1'b0;
    step_check("p2_cpe", S_CPE);
    step_check("p2_da", S_DA);

    // LOAD_AFTER_FULL -> LOAD_DATA, then -> DECODE_ADDRESS on parity_done
    bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
    step_check("p3_lfd", S_LFD);
    step_check("p3_ld", S_LD);
    bus.fifo_full = 1'b1;
    step_check("p3_full", S_FULL);
    bus.fifo_full = 1'b0;
    step_check("p3_laf", S_LAF);
    step_check("p3_laf_to_ld", S_LD);
    bus.fifo_full = 1'b1;
    step_check("p3_full2", S_FULL);
    bus.fifo_full = 1'b0;
    step_check("p3_laf2", S_LAF);
    bus.parity_done = 1'b1;
    bus.pkt_valid = 1'b0;
    step_check("p3_laf_to_da", S_DA);
    bus.parity_done = 1'b0;

    // CHECK_PARITY_ERROR with FIFO full -> FIFO_FULL_STATE
    bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
    step_check("p4_lfd", S_LFD);
    step_check("p4_ld", S_LD);
    bus.pkt_valid = 1'b0;
    step_check("p4_lp", S_LP);
    bus.fifo_full = 1'b1;
    step_check("p4_cpe", S_CPE);
    step_check("p4_cpe_to_full", S_FULL);
    bus.fifo_full = 1'b0;
    step_check("p4_laf", S_LAF);
    bus.parity_done = 1'b1;
    step_check("p4_da", S_DA);
    bus.parity_done = 1'b0;

    // Address 3 ignored; soft reset of another FIFO ignored; own soft reset aborts
    bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
    step_check("addr3_ignored", S_DA);
    step_check("addr3_ignored2", S_DA);
    bus.data_in = 2'd1;
    step_check("p5_lfd", S_LFD);
    step_check("p5_ld", S_LD);
    bus.soft_reset_0 = 1'b1;
    step_check("p5_other_sr", S_LD);
    bus.soft_reset_0 = 1'b0;
    bus.soft_reset_1 = 1'b1;
    step_check("p5_soft_reset", S_DA);
    bus.soft_reset_1 = 1'b0;
    bus.pkt_valid = 1'b0;
    step_check("p5_idle", S_DA);

    // Asynchronous reset mid-LOAD_DATA
    bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
    step_check("p6_lfd", S_LFD);
    step_check("p6_ld", S_LD);
    #2 rst = 1'b0;
    #1 check("async_reset", outs(), S_DA);
    bus.pkt_valid = 1'b0;
    step();
    rst = 1'b1;
    step_check("post_reset_idle", S_DA);

    // WAIT_TILL_EMPTY with FIFO 0 never draining
    bus.fifo_empty_0 = 1'b0;
    bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
    step_check("p7_wte1", S_WTE);
    bus.pkt_valid = 1'b0;
`ifdef ROUTER_FSM_TIMEOUT_EN
    step_check("p7_wte2", S_WTE);
    step_check("p7_wte3", S_WTE);
    step_check("p7_wte4", S_WTE);
    step_check("p7_timeout", S_TO);
    step_check("p7_timeout_drop", S_DA);
`else
    for (int i = 0; i < 100; i++) step_check("p7_wte_forever", S_WTE);
    bus.fifo_empty_0 = 1'b1;
    step_check("p7_lfd", S_LFD);
    bus.soft_reset_0 = 1'b1;
    step_check("p7_soft_reset", S_DA);
    bus.soft_reset_0 = 1'b0;
`endif
    bus.fifo_empty_0 = 1'b1;
    step_check("final_idle", S_DA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
